mmf_arbiter: RTL and testbench

- Shares one 16-entry min/max finder engine among N_REQ requesters.
- The engine holds the array, has a Start input and produces a one-cycle Done.
- Per transaction: arbitrate, stream 16 bytes from the winner into the engine array, pulse engine Start, wait for Done (watchdog-guarded), return Max/Min to the winner.
- Sits between client blocks and the engine; does not drive the engine's own reset.

---
 rtl/mmf_arbiter_if.sv | 41 ++++
 rtl/mmf_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mmf_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmf_arbiter_if.sv
`default_nettype none
// mmf_arbiter_if: client, engine and response signals of the min/max finder arbiter.
// The arbiter connects through the slave modport; the client/engine side uses master.
interface mmf_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int ADDR_W = 4
);
    logic [N_REQ-1:0]  Req;
    logic [N_REQ-1:0]  Grant;
    logic              Ld_Valid;
    logic [7:0]        Ld_Data;
    logic              Ld_Ready;
    logic              Eng_Wr_En;
    logic [ADDR_W-1:0] Eng_Wr_Addr;
    logic [7:0]        Eng_Wr_Data;
    logic              Eng_Start;
    logic              Eng_Done;
    logic [7:0]        Eng_Max;
    logic [7:0]        Eng_Min;
    logic              Rsp_Valid;
    logic [ID_W-1:0]   Rsp_Id;
    logic [7:0]        Rsp_Max;
    logic [7:0]        Rsp_Min;
    logic              Rsp_Err;
    logic              Rsp_Ack;
    logic              Busy;

    modport slave (
        input  Req, Ld_Valid, Ld_Data, Eng_Done, Eng_Max, Eng_Min, Rsp_Ack,
        output Grant, Ld_Ready, Eng_Wr_En, Eng_Wr_Addr, Eng_Wr_Data, Eng_Start,
               Rsp_Valid, Rsp_Id, Rsp_Max, Rsp_Min, Rsp_Err, Busy
    );

    modport master (
        output Req, Ld_Valid, Ld_Data, Eng_Done, Eng_Max, Eng_Min, Rsp_Ack,
        input  Grant, Ld_Ready, Eng_Wr_En, Eng_Wr_Addr, Eng_Wr_Data, Eng_Start,
               Rsp_Valid, Rsp_Id, Rsp_Max, Rsp_Min, Rsp_Err, Busy
    );
endinterface
`default_nettype wire

// File: rtl/mmf_arbiter.sv
`default_nettype none
// mmf_arbiter: shares one 16-entry min/max finder engine among N_REQ requesters.
// Macro MMF_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise lowest index wins.
module mmf_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int WDOG_CYC = 255
) (
    input  logic         Clk,
    input  logic         Resetb,
    mmf_arbiter_if.slave bus
);
    localparam int                WDOG_W    = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

    typedef enum logic [4:0] {
        ARB  = 5'b00001,
        LOAD = 5'b00010,
        KICK = 5'b00100,
        WAIT = 5'b01000,
        RESP = 5'b10000
    } state_t;

    state_t            state, state_nxt;
    logic [N_REQ-1:0]  grant, grant_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [WDOG_W-1:0] wdog, wdog_nxt;
    logic [ID_W-1:0]   cur_id, cur_id_nxt;
    logic [ID_W-1:0]   rsp_id, rsp_id_nxt;
    logic [7:0]        rsp_max, rsp_max_nxt;
    logic [7:0]        rsp_min, rsp_min_nxt;
    logic              rsp_err, rsp_err_nxt;
    logic [ID_W-1:0]   winner;
    logic              ld_ready, wr_en, start, rsp_valid, busy;

`ifdef MMF_ARB_ROUND_ROBIN_EN
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_REQ - 1);
    logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
    int              idx;

    // Descending scan so the requester closest to the pointer is written last and wins.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (bus.Req[ID_W'(idx)]) winner = ID_W'(idx);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Resetb) rr_ptr <= '0;
        else         rr_ptr <= rr_ptr_nxt;
    end
`else
    always_comb begin
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.Req[i]) winner = ID_W'(i);
        end
    end
`endif

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        cnt_nxt     = cnt;
        wdog_nxt    = wdog;
        cur_id_nxt  = cur_id;
        rsp_id_nxt  = rsp_id;
        rsp_max_nxt = rsp_max;
        rsp_min_nxt = rsp_min;
        rsp_err_nxt = rsp_err;
        ld_ready    = 1'b0;
        wr_en       = 1'b0;
        start       = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
`ifdef MMF_ARB_ROUND_ROBIN_EN
        rr_ptr_nxt  = rr_ptr;
`endif
        case (state)
            ARB: begin
                busy      = 1'b0;
                grant_nxt = '0;
                if (|bus.Req) begin
                    grant_nxt[winner] = 1'b1;
                    cur_id_nxt        = winner;
                    cnt_nxt           = '0;
                    state_nxt         = LOAD;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (bus.Ld_Valid) begin
                    wr_en = 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = KICK;
                    end else begin
                        cnt_nxt = cnt + ADDR_W'(1);
                    end
                end
            end
            KICK: begin
                start     = 1'b1;
                wdog_nxt  = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // Done is checked first so a coincident expiry still returns real results.
                if (bus.Eng_Done) begin
                    rsp_max_nxt = bus.Eng_Max;
                    rsp_min_nxt = bus.Eng_Min;
                    rsp_err_nxt = 1'b0;
                    rsp_id_nxt  = cur_id;
                    state_nxt   = RESP;
                end else if (wdog == WDOG_LAST) begin
                    rsp_max_nxt = '0;
                    rsp_min_nxt = '0;
                    rsp_err_nxt = 1'b1;
                    rsp_id_nxt  = cur_id;
                    state_nxt   = RESP;
                end else begin
                    wdog_nxt = wdog + WDOG_W'(1);
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.Rsp_Ack) begin
                    grant_nxt = '0;
                    state_nxt = ARB;
`ifdef MMF_ARB_ROUND_ROBIN_EN
                    rr_ptr_nxt = (cur_id == ID_LAST) ? '0 : cur_id + ID_W'(1);
`endif
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = ARB;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Resetb) begin
            state   <= ARB;
            grant   <= '0;
            cnt     <= '0;
            wdog    <= '0;
            cur_id  <= '0;
            rsp_id  <= '0;
            rsp_max <= '0;
            rsp_min <= '0;
            rsp_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            cnt     <= cnt_nxt;
            wdog    <= wdog_nxt;
            cur_id  <= cur_id_nxt;
            rsp_id  <= rsp_id_nxt;
            rsp_max <= rsp_max_nxt;
            rsp_min <= rsp_min_nxt;
            rsp_err <= rsp_err_nxt;
        end
    end

    assign bus.Grant       = grant;
    assign bus.Ld_Ready    = ld_ready;
    assign bus.Eng_Wr_En   = wr_en;
    assign bus.Eng_Wr_Addr = cnt;
    assign bus.Eng_Wr_Data = bus.Ld_Data;
    assign bus.Eng_Start   = start;
    assign bus.Rsp_Valid   = rsp_valid;
    assign bus.Rsp_Id      = rsp_id;
    assign bus.Rsp_Max     = rsp_max;
    assign bus.Rsp_Min     = rsp_min;
    assign bus.Rsp_Err     = rsp_err;
    assign bus.Busy        = busy;
endmodule
`default_nettype wire

// File: tb/tb_mmf_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// tb_mmf_arbiter: directed self-checking bench for mmf_arbiter with a behavioural engine model.
module tb_mmf_arbiter;
    localparam int N_REQ = 4, ID_W = 2, DEPTH = 16, ADDR_W = 4, WDOG_CYC = 255;

    logic Clk = 1'b0;
    logic Resetb = 1'b0;
    always #5 Clk = ~Clk;

    mmf_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W)) bus();

    mmf_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WDOG_CYC(WDOG_CYC)) dut (
        .Clk(Clk), .Resetb(Resetb), .bus(bus)
    );

    int checks = 0;
    int passed = 0;

    // min 0x03, max 0xF0
    logic [7:0] data_a [16] = '{8'h10, 8'h03, 8'h44, 8'h87, 8'h22, 8'h9A, 8'h5C, 8'hE1,
                                8'h3B, 8'h71, 8'h08, 8'hC6, 8'h2D, 8'hB4, 8'h69, 8'hF0};
    // min 0x01, max 0xFE
    logic [7:0] data_b [16] = '{8'h7F, 8'h80, 8'h01, 8'hFE, 8'h33, 8'h44, 8'h55, 8'h66,
                                8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

    logic [7:0]        mem    [DEPTH];
    logic [ADDR_W-1:0] wr_log [512];
    int wr_cnt = 0, start_cnt = 0, cyc = 0, start_cyc = 0, wr_at_start = 0;
    int eng_timer = 0, eng_delay = 0;

    function automatic logic [7:0] mem_max();
        logic [7:0] m;
        m = mem[0];
        for (int i = 1; i < DEPTH; i++) if (mem[i] > m) m = mem[i];
        return m;
    endfunction

    function automatic logic [7:0] mem_min();
        logic [7:0] m;
        m = mem[0];
        for (int i = 1; i < DEPTH; i++) if (mem[i] < m) m = mem[i];
        return m;
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    // Engine model and write/start monitor; eng_delay==0 means Done never comes.
    always @(negedge Clk) begin
        bus.Eng_Done <= 1'b0;
        if (bus.Eng_Wr_En === 1'b1) begin
            mem[bus.Eng_Wr_Addr]  <= bus.Eng_Wr_Data;
            wr_log[wr_cnt % 512]  <= bus.Eng_Wr_Addr;
            wr_cnt                <= wr_cnt + 1;
        end
        if (bus.Eng_Start === 1'b1) begin
            start_cnt   <= start_cnt + 1;
            start_cyc   <= cyc;
            wr_at_start <= wr_cnt;
            eng_timer   <= eng_delay;
        end else if (eng_timer > 0) begin
            if (eng_timer == 1) begin
                bus.Eng_Done <= 1'b1;
                bus.Eng_Max  <= mem_max();
                bus.Eng_Min  <= mem_min();
            end
            eng_timer <= eng_timer - 1;
        end
    end

    task automatic do_load(input string name, input int set, input bit gap, input int nbeats);
        int idx;
        int guard;
        bit tog;
        bit vld;
        idx = 0; guard = 0; tog = 1'b0;
        while (idx < nbeats && guard < 200) begin
            @(posedge Clk); #1;
            guard++;
            vld = !(gap && tog);
            tog = !tog;
            bus.Ld_Valid = vld;
            bus.Ld_Data  = (set == 0) ? data_a[idx] : data_b[idx];
            if (vld && bus.Ld_Ready === 1'b1) idx++;
        end
        @(posedge Clk); #1;
        bus.Ld_Valid = 1'b0;
        checks++;
        if (idx !== nbeats) $display("FAIL %s load_beats: accepted %0d, required %0d", name, idx, nbeats);
        else passed++;
    endtask

    task automatic run_txn(input string name, input logic [N_REQ-1:0] req, input int set, input bit gap,
                           input int delay, input logic [N_REQ-1:0] exp_grant, input logic [ID_W-1:0] exp_id,
                           input logic [7:0] exp_max, input logic [7:0] exp_min, input logic exp_err,
                           input bit drop_req, input int exp_lat);
        int base;
        int sbase;
        int g;
        base = wr_cnt; sbase = start_cnt; eng_delay = delay;
        bus.Req = req;
        g = 0;
        do begin @(posedge Clk); #1; g++; end while (bus.Grant === '0 && g < 10);
        checks++;
        if (g !== 1) $display("FAIL %s grant_latency: got %0d cycles, required 1", name, g); else passed++;
        checks++;
        if (bus.Grant !== exp_grant) $display("FAIL %s grant: got %b, required %b", name, bus.Grant, exp_grant);
        else passed++;
        checks++;
        if (bus.Busy !== 1'b1 || bus.Ld_Ready !== 1'b1)
            $display("FAIL %s load_state: busy=%b ld_ready=%b, required 1/1", name, bus.Busy, bus.Ld_Ready);
        else passed++;
        if (drop_req) bus.Req = '0;

        do_load(name, set, gap, 16);

        g = 0;
        while (bus.Rsp_Valid !== 1'b1 && g < 1000) begin @(negedge Clk); g++; end
        checks++;
        if (bus.Rsp_Valid !== 1'b1) $display("FAIL %s rsp_valid: got %b, required 1", name, bus.Rsp_Valid);
        else passed++;
        checks++;
        if (bus.Rsp_Id !== exp_id) $display("FAIL %s rsp_id: got %0d, required %0d", name, bus.Rsp_Id, exp_id);
        else passed++;
        checks++;
        if (bus.Rsp_Max !== exp_max) $display("FAIL %s rsp_max: got %h, required %h", name, bus.Rsp_Max, exp_max);
        else passed++;
        checks++;
        if (bus.Rsp_Min !== exp_min) $display("FAIL %s rsp_min: got %h, required %h", name, bus.Rsp_Min, exp_min);
        else passed++;
        checks++;
        if (bus.Rsp_Err !== exp_err) $display("FAIL %s rsp_err: got %b, required %b", name, bus.Rsp_Err, exp_err);
        else passed++;
        checks++;
        if (wr_cnt - base !== 16) $display("FAIL %s write_count: got %0d, required 16", name, wr_cnt - base);
        else passed++;
        checks++;
        if (start_cnt - sbase !== 1) $display("FAIL %s start_count: got %0d, required 1", name, start_cnt - sbase);
        else passed++;
        checks++;
        if (wr_at_start - base !== 16)
            $display("FAIL %s writes_before_start: got %0d, required 16", name, wr_at_start - base);
        else passed++;
        checks++;
        if (cyc - start_cyc !== exp_lat)
            $display("FAIL %s start_to_valid: got %0d cycles, required %0d", name, cyc - start_cyc, exp_lat);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (wr_log[(base + i) % 512] !== ADDR_W'(i))
                $display("FAIL %s write_addr[%0d]: got %0d, required %0d", name, i, wr_log[(base + i) % 512], i);
            else passed++;
        end

        @(posedge Clk); #1;
        checks++;
        if (bus.Rsp_Valid !== 1'b1 || bus.Rsp_Max !== exp_max)
            $display("FAIL %s rsp_hold: valid=%b max=%h, required 1/%h", name, bus.Rsp_Valid, bus.Rsp_Max, exp_max);
        else passed++;
        bus.Rsp_Ack = 1'b1;
        @(posedge Clk); #1;
        bus.Rsp_Ack = 1'b0;
        checks++;
        if (bus.Rsp_Valid !== 1'b0 || bus.Grant !== '0 || bus.Busy !== 1'b0)
            $display("FAIL %s after_ack: valid=%b grant=%b busy=%b, required 0/0000/0",
                     name, bus.Rsp_Valid, bus.Grant, bus.Busy);
        else passed++;
        checks++;
        if (bus.Rsp_Max !== exp_max || bus.Rsp_Min !== exp_min)
            $display("FAIL %s fields_after_ack: max=%h min=%h, required %h/%h",
                     name, bus.Rsp_Max, bus.Rsp_Min, exp_max, exp_min);
        else passed++;
    endtask

    task automatic test_reset();
        bus.Req = '0; bus.Ld_Valid = 1'b0; bus.Ld_Data = '0; bus.Rsp_Ack = 1'b0;
        Resetb = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (bus.Grant !== '0 || bus.Busy !== 1'b0 || bus.Rsp_Valid !== 1'b0)
            $display("FAIL reset_ctrl: grant=%b busy=%b valid=%b, required 0000/0/0",
                     bus.Grant, bus.Busy, bus.Rsp_Valid);
        else passed++;
        checks++;
        if (bus.Rsp_Max !== 8'h00 || bus.Rsp_Min !== 8'h00 || bus.Rsp_Id !== '0 || bus.Rsp_Err !== 1'b0)
            $display("FAIL reset_rsp: max=%h min=%h id=%0d err=%b, required 00/00/0/0",
                     bus.Rsp_Max, bus.Rsp_Min, bus.Rsp_Id, bus.Rsp_Err);
        else passed++;
        checks++;
        if (bus.Ld_Ready !== 1'b0 || bus.Eng_Wr_En !== 1'b0 || bus.Eng_Start !== 1'b0)
            $display("FAIL reset_strobes: ld_ready=%b wr_en=%b start=%b, required 0/0/0",
                     bus.Ld_Ready, bus.Eng_Wr_En, bus.Eng_Start);
        else passed++;
        Resetb = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_single();
        run_txn("single", 4'b0001, 0, 1'b0, 40, 4'b0001, 2'd0, 8'hF0, 8'h03, 1'b0, 1'b1, 41);
    endtask

    task automatic test_gap();
        run_txn("gap", 4'b0010, 1, 1'b1, 5, 4'b0010, 2'd1, 8'hFE, 8'h01, 1'b0, 1'b1, 6);
    endtask

    task automatic test_watchdog();
        run_txn("watchdog", 4'b0100, 0, 1'b0, 0, 4'b0100, 2'd2, 8'h00, 8'h00, 1'b1, 1'b1, 256);
    endtask

    task automatic test_coincide();
        run_txn("coincide", 4'b1000, 1, 1'b0, 255, 4'b1000, 2'd3, 8'hFE, 8'h01, 1'b0, 1'b1, 256);
    endtask

    task automatic test_back_to_back();
        logic [N_REQ-1:0] eg;
        logic [ID_W-1:0]  eid;
        for (int k = 0; k < 4; k++) begin
`ifdef MMF_ARB_ROUND_ROBIN_EN
            eg  = 4'b0001 << k;
            eid = ID_W'(k);
`else
            eg  = 4'b0001;
            eid = 2'd0;
`endif
            run_txn("contention", 4'b1111, k % 2, 1'b0, 3, eg, eid,
                    (k % 2 == 0) ? 8'hF0 : 8'hFE, (k % 2 == 0) ? 8'h03 : 8'h01, 1'b0, 1'b0, 4);
        end
        bus.Req = '0;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_mid_load();
        int base;
        int g;
        int seen;
        bus.Req = 4'b0100;
        g = 0;
        do begin @(posedge Clk); #1; g++; end while (bus.Grant === '0 && g < 10);
        bus.Req = '0;
        base = wr_cnt;
        do_load("midload", 0, 1'b0, 7);
        Resetb = 1'b0;
        @(posedge Clk); #1;
        Resetb = 1'b1;
        checks++;
        if (bus.Grant !== '0 || bus.Busy !== 1'b0 || bus.Rsp_Valid !== 1'b0)
            $display("FAIL midload_reset: grant=%b busy=%b valid=%b, required 0000/0/0",
                     bus.Grant, bus.Busy, bus.Rsp_Valid);
        else passed++;
        checks++;
        if (wr_cnt - base !== 7) $display("FAIL midload_writes: got %0d, required 7", wr_cnt - base);
        else passed++;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            if (bus.Rsp_Valid !== 1'b0 || bus.Busy !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL midload_idle: active cycles %0d, required 0", seen);
        else passed++;
        run_txn("after_reset", 4'b1010, 0, 1'b0, 2, 4'b0010, 2'd1, 8'hF0, 8'h03, 1'b0, 1'b1, 3);
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_watchdog();
        test_coincide();
        test_back_to_back();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
